// File: rtl/quad_adder_pkg.sv
// Shared definitions for the quad serial adder control path: FSM state
// encoding, the strobe bundle decoded from each state, and default sizes.
package quad_adder_pkg;

  localparam int NIBBLES_DEF = 16;  // 4-bit steps per operation (64-bit operands)
  localparam int CNT_W_DEF   = 4;   // step counter width, 2^CNT_W >= NIBBLES
  localparam int NIBBLE_W    = 4;   // bits consumed per ADD step

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Strobes driven towards the datapath; one bundle per state.
  typedef struct packed {
    logic load_ab;  // parallel-load A and B
    logic zero_r;   // clear result register
    logic zero_d;   // clear carry flop
    logic enb;      // shift A, B and R by one nibble
    logic busy;
    logic done;
  } ctrl_t;

  // Moore decode: the strobe set belonging to a given state.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_LOAD: begin
        c.load_ab = 1'b1;
        c.zero_r  = 1'b1;
        c.zero_d  = 1'b1;
        c.busy    = 1'b1;
      end
      ST_ADD: begin
        c.enb  = 1'b1;
        c.busy = 1'b1;
      end
      ST_DONE: begin
        c.done   = 1'b1;
        c.zero_d = 1'b1;
        c.busy   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/quad_step_counter.sv
// Nibble step counter for the quad adder controller. Synchronous clear and
// enable, terminal count flag at NIBBLES-1, asynchronous active-high reset.
module quad_step_counter
  import quad_adder_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  // Step count: clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/quad_adder_ctrl.sv
// Control FSM for the quad (4-bit-per-cycle) serial adder datapath.
// Sequence: IDLE -> LOAD (1 cycle) -> ADD (NIBBLES cycles) -> DONE (1 cycle).
// Optional macro QUAD_ADDER_OVERFLOW_EN builds the overflow register that
// captures the final carry; without it overflow is constant 0.
//
// Handshake: start is a level request sampled only while IDLE; there is no
// ready/ack, a request outside IDLE is dropped, and done is a one-cycle pulse
// marking the last cycle of the operation.
module quad_adder_ctrl
  import quad_adder_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             carry_out,
  output logic             enbA,
  output logic             enbB,
  output logic             enbR,
  output logic             loadA,
  output logic             loadB,
  output logic             loadR,
  output logic             zeroA,
  output logic             zeroB,
  output logic             zeroR,
  output logic             zeroD,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output state_t           dbg_state,
  output logic [CNT_W-1:0] dbg_step
);

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] step;
  logic             last_step;

  // Next-state rule; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_ADD;
      ST_ADD:  if (last_step) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register with strobes registered alongside it, decoded from the
  // state being entered so they line up exactly with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ctrl  <= '0;
    end else begin
      state <= state_nxt;
      ctrl  <= decode_ctrl(state_nxt);
    end
  end

  // Counter is cleared in LOAD and held at its terminal value on the last
  // ADD step, so it never wraps while ADD is active.
  quad_step_counter #(
    .NIBBLES (NIBBLES),
    .CNT_W   (CNT_W)
  ) u_step (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == ST_LOAD),
    .en    ((state == ST_ADD) && !last_step),
    .count (step),
    .tc    (last_step)
  );

`ifdef QUAD_ADDER_OVERFLOW_EN
  // Capture the carry of the final nibble on the edge leaving DONE; the
  // datapath clears its carry flop on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (state == ST_DONE) begin
      overflow <= carry_out;
    end
  end
`else
  logic carry_unused;
  assign carry_unused = carry_out;
  assign overflow     = 1'b0;
`endif

  assign loadA = ctrl.load_ab;
  assign loadB = ctrl.load_ab;
  assign loadR = 1'b0;
  assign enbA  = ctrl.enb;
  assign enbB  = ctrl.enb;
  assign enbR  = ctrl.enb;
  assign zeroA = 1'b0;
  assign zeroB = 1'b0;
  assign zeroR = ctrl.zero_r;
  assign zeroD = ctrl.zero_d;
  assign busy  = ctrl.busy;
  assign done  = ctrl.done;

  assign dbg_state = state;
  assign dbg_step  = step;

endmodule

// File: doc/quad_adder_ctrl.md
# quad_adder_ctrl

Control FSM for the quad (4-bit-per-cycle) serial adder datapath. It accepts a start request, drives the datapath control strobes: parallel-load A/B, clear R and carry, then shift-and-add one nibble per cycle for all nibbles. It then reports completion and, optionally, the final carry. It sits directly upstream of the datapath and drives its complete control interface.

## Interface
Parameters:
- `NIBBLES`, default 16: number of 4-bit add steps (64-bit operands).
- `CNT_W`, default 4: step counter width; must satisfy 2^CNT_W ≥ NIBBLES.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: operation request; sampled only in IDLE.
- `carry_out` in 1: datapath carry flop output.
- `enbA`, `enbB`, `enbR` out 1 each: shift enables for registers A, B and R.
- `loadA`, `loadB`, `loadR` out 1 each: parallel-load strobes. `loadR` is always 0.
- `zeroA`, `zeroB`, `zeroR`, `zeroD` out 1 each: synchronous clears for A, B, R and the carry flop.
- `busy` out 1: high in LOAD, ADD and DONE.
- `done` out 1: one-cycle completion pulse.
- `overflow` out 1: final carry of the last operation (see Configuration).

## Operation
- States: IDLE, LOAD, ADD, DONE. All control outputs are Moore-decoded from the state register. No output depends combinationally on `start`.
- IDLE:
  - All strobes are 0.
  - `start`=1 → LOAD. Otherwise the FSM stays in IDLE.
- LOAD, exactly 1 cycle:
  - Drives `loadA`=`loadB`=1 and `zeroR`=`zeroD`=1.
  - Clears the step counter.
  - Next state is ADD.
- ADD, exactly NIBBLES cycles:
  - Drives `enbA`=`enbB`=`enbR`=1.
  - The counter increments each cycle.
  - When the counter reaches NIBBLES-1, the next state is DONE.
- DONE, exactly 1 cycle:
  - Drives `done`=1 and `zeroD`=1.
  - On the closing edge, `overflow` captures `carry_out`. This is the old value, i.e. the carry out of the final nibble. The carry flop clears on the same edge.
  - Next state is IDLE.
- `start` outside IDLE is ignored and is not queued. If `start` is held high, a new operation begins in the cycle following the return to IDLE.
- `zeroA`/`zeroB` are always 0. They are driven as constant outputs for datapath port completeness.
- Counter arithmetic is unsigned, CNT_W bits, and never wraps within ADD.
- The result register contents stay stable from DONE until the next LOAD.

## Timing
- Reset, asynchronous and immediate:
  - State = IDLE, counter = 0, `overflow` = 0.
  - Every output is 0.
- Reset asserted mid-operation aborts to IDLE and clears `overflow`. Datapath register contents are then undefined to the user.
- Latency, with `start` sampled at edge E0:
  - LOAD runs from E0 to E1.
  - ADD spans E1 to E(NIBBLES+1).
  - DONE runs from E(NIBBLES+1) to E(NIBBLES+2).
  - The FSM is back in IDLE after E(NIBBLES+2).
  - With NIBBLES=16, `done` is high in the 18th cycle after the start-sampling edge.
- Throughput: one operation per NIBBLES+3 cycles with `start` held high.
- `overflow` is valid from the cycle after DONE until the next DONE or reset.
- `busy` falls on the same edge that leaves DONE.

## Configuration
- `QUAD_ADDER_OVERFLOW_EN`:
  - Defined: the `overflow` register exists and behaves as above.
  - Undefined: no register is built, `overflow` is tied to constant 0, and `carry_out` is unused.
- FSM sequencing and latency are identical in both builds.

## Structure
- Shared package `quad_adder_pkg` holds:
  - the state enum (IDLE, LOAD, ADD, DONE) with a 2-bit encoding;
  - the default `NIBBLES`/`CNT_W` constants;
  - the nibble width constant (4).
- One sub-module, `quad_step_counter`:
  - synchronous clear and enable;
  - terminal-count output at NIBBLES-1;
  - asynchronous active-high reset.
- The FSM and output decode live in the top module.

## Test plan
- Nominal, with the controller connected to the datapath:
  - Stimulus: A=0x0000_0000_0000_0001, B=0x0000_0000_0000_0001, one-cycle `start`.
  - Expected: LOAD strobes for exactly 1 cycle, `enbA/B/R` for exactly 16 cycles, `done` pulse in cycle 18, result=0x2, `overflow`=0.
- Carry propagation:
  - Stimulus: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1.
  - Expected: result=0x0, `overflow`=1, `carry_out`=0 the cycle after DONE.
- Held `start` for 3 operations:
  - Expected: the LOAD cycles of successive operations are exactly 19 cycles apart, with `done` pulsing 3 times.
- `start` pulsed during ADD and during DONE:
  - Expected: the pulse is ignored; exactly one `done` occurs and the FSM returns to IDLE.
- Reset asserted on ADD cycle 7:
  - Expected: all outputs are 0 immediately and `overflow`=0. A subsequent start completes normally in 18 cycles.
- Build without `QUAD_ADDER_OVERFLOW_EN`, repeating the carry-propagation case:
  - Expected: `overflow` stays 0 and the strobe timing is identical to the macro-enabled build.
